// File: rtl/dmem_arb_pkg.sv
// Shared types and lane-steering helpers for the data-memory port arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  typedef struct packed {
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } lane_t;

  // Misaligned halves/words keep the aligned-down byte mask.
  function automatic lane_t lane_steer(
    input logic [1:0]  size,
    input logic [1:0]  off,
    input logic [31:0] data
  );
    lane_t l;
    l.wmask = 4'hF;
    l.wdata = data;
    case (size)
      SZ_B: begin
        l.wmask = 4'b0001 << off;
        l.wdata = {4{data[7:0]}};
      end
      SZ_H: begin
        l.wmask = 4'b0011 << (off & 2'b10);
        l.wdata = {2{data[15:0]}};
      end
      default: begin
        l.wmask = 4'hF;
        l.wdata = data;
      end
    endcase
    return l;
  endfunction

  function automatic logic is_misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic m;
    case (size)
      SZ_B:    m = 1'b0;
      SZ_H:    m = off[0];
      default: m = (off != 2'b00);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_rr_arbiter2.sv
// Two-way round-robin grant; the last winner loses the next tie.
module dmem_rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic       gnt_o
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt_o = REQ_CPU;
    case (req_i)
      2'b01:   gnt_o = REQ_CPU;
      2'b10:   gnt_o = REQ_DBG;
      2'b11:   gnt_o = ~last_q;
      default: gnt_o = REQ_CPU;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (advance_i) last_d = gnt_o;
  end

  always_ff @(posedge clock) begin
    if (reset) last_q <= REQ_DBG;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates CPU and loader requesters onto one data-memory port,
// tracking a single outstanding transaction with a response timeout.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        r0_req_valid,
  output logic        r0_req_ready,
  input  logic        r0_req_we,
  input  logic [31:0] r0_req_addr,
  input  logic [31:0] r0_req_data,
  input  logic [1:0]  r0_req_size,
  output logic        r0_resp_valid,
  output logic [31:0] r0_resp_data,

  input  logic        r1_req_valid,
  output logic        r1_req_ready,
  input  logic        r1_req_we,
  input  logic [31:0] r1_req_addr,
  input  logic [31:0] r1_req_data,
  input  logic [1:0]  r1_req_size,
  output logic        r1_resp_valid,
  output logic [31:0] r1_resp_data,

  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_we,
  output logic [31:0] mem_req_addr,
  output logic [3:0]  mem_req_wmask,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,

  output logic        timeout_err,
  output logic        misalign_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_e state_q, state_d;

  logic          gnt;
  logic          accept;
  logic          tmo_hit;
  logic          sel_we;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_data;
  logic [1:0]    sel_size;
  lane_t         lane;

  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    wmask_q, wmask_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          terr_q, terr_d;

  dmem_rr_arbiter2 u_rr (
    .clock     (clock),
    .reset     (reset),
    .req_i     ({r1_req_valid, r0_req_valid}),
    .advance_i (accept),
    .gnt_o     (gnt)
  );

  assign accept = (state_q == ST_IDLE) && (r0_req_valid || r1_req_valid);
  assign tmo_hit = (state_q == ST_WAIT) && (cnt_q == CW'(TIMEOUT_CYCLES));

  always_comb begin
    sel_we   = r0_req_we;
    sel_addr = r0_req_addr;
    sel_data = r0_req_data;
    sel_size = r0_req_size;
    if (gnt == REQ_DBG) begin
      sel_we   = r1_req_we;
      sel_addr = r1_req_addr;
      sel_data = r1_req_data;
      sel_size = r1_req_size;
    end
  end

  assign lane = lane_steer(sel_size, sel_addr[1:0], sel_data);

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:
        if (accept) state_d = ST_ISSUE;
      ST_ISSUE:
        if (mem_req_ready)
          state_d = mem_resp_valid ? ST_RESP : ST_WAIT;
      ST_WAIT:
        if (mem_resp_valid || tmo_hit) state_d = ST_RESP;
      ST_RESP:
        state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    r0_req_ready  = 1'b0;
    r1_req_ready  = 1'b0;
    mem_req_valid = 1'b0;
    r0_resp_valid = 1'b0;
    r1_resp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        r0_req_ready = r0_req_valid && (gnt == REQ_CPU);
        r1_req_ready = r1_req_valid && (gnt == REQ_DBG);
      end
      ST_ISSUE:
        mem_req_valid = 1'b1;
      ST_RESP: begin
        r0_resp_valid = (owner_q == REQ_CPU);
        r1_resp_valid = (owner_q == REQ_DBG);
      end
      default: ;
    endcase
  end

  always_comb begin
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wmask_d = wmask_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    terr_d  = terr_q;
    if (accept) begin
      owner_d = gnt;
      we_d    = sel_we;
      addr_d  = {sel_addr[31:2], 2'b00};
      wmask_d = sel_we ? lane.wmask : 4'hF;
      wdata_d = sel_we ? lane.wdata : 32'h0;
    end
    if ((state_q == ST_ISSUE) && mem_req_ready) begin
      cnt_d = '0;
      if (mem_resp_valid) rdata_d = mem_resp_data;
    end
    if (state_q == ST_WAIT) begin
      cnt_d = cnt_q + CW'(1);
      if (mem_resp_valid) begin
        rdata_d = mem_resp_data;
      end else if (tmo_hit) begin
        rdata_d = ERR_DATA;
        terr_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q <= REQ_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wmask_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wmask_q <= wmask_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
    end
  end

  assign mem_req_we    = we_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wmask = wmask_q;
  assign mem_req_wdata = wdata_q;
  assign r0_resp_data  = rdata_q;
  assign r1_resp_data  = rdata_q;
  assign timeout_err   = terr_q;
  assign misalign_err  = accept && is_misaligned(sel_size, sel_addr[1:0]);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: transaction-level model checked every cycle
// plus directed scenarios with literal expectations.
module tb_dmem_port_arbiter;

  localparam int          TO  = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        r0_req_valid = 0, r0_req_we = 0;
  logic [31:0] r0_req_addr = 0, r0_req_data = 0;
  logic [1:0]  r0_req_size = 0;
  logic        r0_req_ready, r0_resp_valid;
  logic [31:0] r0_resp_data;
  logic        r1_req_valid = 0, r1_req_we = 0;
  logic [31:0] r1_req_addr = 0, r1_req_data = 0;
  logic [1:0]  r1_req_size = 0;
  logic        r1_req_ready, r1_resp_valid;
  logic [31:0] r1_resp_data;
  logic        mem_req_valid, mem_req_we;
  logic        mem_req_ready = 0, mem_resp_valid = 0;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic [31:0] mem_resp_data = 0;
  logic        timeout_err, misalign_err;

  always #5 clock = ~clock;

  dmem_port_arbiter #(.TIMEOUT_CYCLES(TO), .ERR_DATA(ERR)) dut (
    .clock(clock), .reset(reset),
    .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready),
    .r0_req_we(r0_req_we), .r0_req_addr(r0_req_addr),
    .r0_req_data(r0_req_data), .r0_req_size(r0_req_size),
    .r0_resp_valid(r0_resp_valid), .r0_resp_data(r0_resp_data),
    .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready),
    .r1_req_we(r1_req_we), .r1_req_addr(r1_req_addr),
    .r1_req_data(r1_req_data), .r1_req_size(r1_req_size),
    .r1_resp_valid(r1_resp_valid), .r1_resp_data(r1_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wmask(mem_req_wmask), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .timeout_err(timeout_err), .misalign_err(misalign_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference lanes: byte i enabled when it falls in the same aligned
  // nb-byte group as the offset; each lane takes data byte (i mod nb).
  function automatic logic [35:0] ref_lanes(input logic we,
      input logic [1:0] size, input logic [1:0] off, input logic [31:0] d);
    int nb;
    int o;
    logic [3:0] m;
    logic [31:0] w;
    if (!we) return {4'hF, 32'h0};
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    o = int'(off);
    for (int i = 0; i < 4; i++) begin
      m[i] = ((i / nb) == (o / nb));
      w[8*i +: 8] = d[8*(i % nb) +: 8];
    end
    return {m, w};
  endfunction

  function automatic bit ref_misal(input logic [1:0] size,
                                   input logic [1:0] off);
    int nb;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    return (int'(off) % nb) != 0;
  endfunction

  // memory responder knobs
  int          mem_stall = 0;
  bit          mem_mute  = 0;
  logic [31:0] mem_word  = 0;

  initial begin
    int sc;
    sc = 0;
    forever begin
      @(posedge clock); #1;
      mem_req_ready  = 0;
      mem_resp_valid = 0;
      if (reset) sc = 0;
      else if (mem_req_valid) begin
        if (sc < mem_stall) sc++;
        else begin
          sc = 0;
          mem_req_ready = 1;
          if (!mem_mute) begin
            mem_resp_valid = 1;
            mem_resp_data  = mem_word;
          end
        end
      end
    end
  end

  // model state and observation logs
  bit          m_busy = 0, m_issued = 0, m_resp_now = 0, m_terr = 0;
  int          m_last = 1, m_wait = 0, m_owner = 0;
  logic        m_we = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_rdata = 0;
  logic [3:0]  m_mask = 0;
  int          cyc = 0, acc_cyc = 0, hs_cyc = 0, resp_cyc = 0;
  int          resp_owner = 0, resp_cnt = 0, mis_cnt = 0, memv_cnt = 0;
  logic [31:0] resp_dat = 0, hs_addr = 0, hs_wdata = 0;
  logic [3:0]  hs_mask = 0;
  int          acc_q[$];

  initial begin
    int win;
    bit e0, e1, acc;
    logic s_we;
    logic [31:0] s_addr, s_data;
    logic [1:0] s_size;
    logic [35:0] ln;
    forever begin
      @(negedge clock);
      cyc++;
      if (r0_req_valid && r1_req_valid) win = (m_last == 0) ? 1 : 0;
      else win = r0_req_valid ? 0 : 1;
      e0 = !m_busy && r0_req_valid && (win == 0);
      e1 = !m_busy && r1_req_valid && (win == 1);
      acc = e0 || e1;
      s_we   = win ? r1_req_we   : r0_req_we;
      s_addr = win ? r1_req_addr : r0_req_addr;
      s_data = win ? r1_req_data : r0_req_data;
      s_size = win ? r1_req_size : r0_req_size;
      chk("r0_req_ready", r0_req_ready, e0);
      chk("r1_req_ready", r1_req_ready, e1);
      chk("misalign_err", misalign_err,
          acc && ref_misal(s_size, s_addr[1:0]));
      chk("mem_req_valid", mem_req_valid, m_busy && !m_issued);
      if (m_busy && !m_issued) begin
        chk("mem_req_we", mem_req_we, m_we);
        chk("mem_req_addr", mem_req_addr, m_addr);
        chk("mem_req_wmask", mem_req_wmask, m_mask);
        chk("mem_req_wdata", mem_req_wdata, m_wdata);
      end
      chk("r0_resp_valid", r0_resp_valid, m_resp_now && m_owner == 0);
      chk("r1_resp_valid", r1_resp_valid, m_resp_now && m_owner == 1);
      if (m_resp_now)
        chk("resp_data", m_owner ? r1_resp_data : r0_resp_data, m_rdata);
      chk("timeout_err", timeout_err, m_terr);

      if (r0_req_ready) begin acc_q.push_back(0); acc_cyc = cyc; end
      if (r1_req_ready) begin acc_q.push_back(1); acc_cyc = cyc; end
      if (mem_req_valid) memv_cnt++;
      if (mem_req_valid && mem_req_ready) begin
        hs_cyc = cyc; hs_addr = mem_req_addr;
        hs_mask = mem_req_wmask; hs_wdata = mem_req_wdata;
      end
      if (r0_resp_valid || r1_resp_valid) begin
        resp_cnt++; resp_cyc = cyc;
        resp_owner = r1_resp_valid ? 1 : 0;
        resp_dat = r1_resp_valid ? r1_resp_data : r0_resp_data;
      end
      if (misalign_err) mis_cnt++;

      if (reset) begin
        m_busy = 0; m_issued = 0; m_resp_now = 0;
        m_last = 1; m_terr = 0; m_wait = 0;
      end else if (m_resp_now) begin
        m_resp_now = 0; m_busy = 0;
      end else if (!m_busy) begin
        if (acc) begin
          ln = ref_lanes(s_we, s_size, s_addr[1:0], s_data);
          m_busy = 1; m_issued = 0; m_owner = win; m_last = win;
          m_we = s_we; m_addr = s_addr & 32'hFFFF_FFFC;
          m_mask = ln[35:32]; m_wdata = ln[31:0];
        end
      end else if (!m_issued) begin
        if (mem_req_ready) begin
          m_issued = 1; m_wait = 0;
          if (mem_resp_valid) begin m_resp_now = 1; m_rdata = mem_resp_data; end
        end
      end else begin
        if (mem_resp_valid) begin
          m_resp_now = 1; m_rdata = mem_resp_data;
        end else if (m_wait == TO) begin
          m_resp_now = 1; m_rdata = ERR; m_terr = 1;
        end else m_wait++;
      end
    end
  end

  task automatic set_req(input int n, input logic v, input logic we,
      input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    if (n == 0) begin
      r0_req_valid = v; r0_req_we = we; r0_req_addr = a;
      r0_req_data = d; r0_req_size = sz;
    end else begin
      r1_req_valid = v; r1_req_we = we; r1_req_addr = a;
      r1_req_data = d; r1_req_size = sz;
    end
  endtask

  task automatic do_req(input int n, input logic we, input logic [31:0] a,
      input logic [31:0] d, input logic [1:0] sz);
    bit got;
    @(posedge clock); #1;
    set_req(n, 1, we, a, d, sz);
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clock);
      got = (n == 0) ? r0_req_ready : r1_req_ready;
    end
    chk("accept_seen", got, 1);
    @(posedge clock); #1;
    set_req(n, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_resp();
    bit got;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clock);
      got = r0_resp_valid || r1_resp_valid;
    end
    chk("resp_seen", got, 1);
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1;
    repeat (2) @(posedge clock);
    #1 reset = 0;
  endtask

  initial begin
    int m0, r0c;
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int mis0, rc0;
    repeat (3) @(posedge clock);
    #1 reset = 0;
    @(negedge clock);
    chk("rst mem_req_valid", mem_req_valid, 0);
    chk("rst resp_valid", {r1_resp_valid, r0_resp_valid}, 0);
    chk("rst timeout_err", timeout_err, 0);
    chk("rst misalign_err", misalign_err, 0);

    // tie fairness: both valid continuously
    mem_word = 32'h1111_0000;
    @(posedge clock); #1;
    set_req(0, 1, 0, 32'h10, 0, 2);
    set_req(1, 1, 0, 32'h20, 0, 2);
    for (int k = 0; k < 60 && acc_q.size() < 4; k++) @(negedge clock);
    @(posedge clock); #1;
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    repeat (4) @(negedge clock);
    chk("tie count", acc_q.size(), 4);
    if (acc_q.size() >= 4) begin
      chk("tie g0", acc_q[0], 0);
      chk("tie g1", acc_q[1], 1);
      chk("tie g2", acc_q[2], 0);
      chk("tie g3", acc_q[3], 1);
    end

    do_reset();

    // single zero-wait load
    mem_word = 32'h1234_5678;
    do_req(0, 0, 32'h100, 0, 2);
    wait_resp();
    chk("load latency", resp_cyc - acc_cyc, 2);
    chk("load issue", hs_cyc - acc_cyc, 1);
    chk("load data", resp_dat, 32'h1234_5678);
    chk("load owner", resp_owner, 0);
    chk("load addr", hs_addr, 32'h100);

    // byte store from loader
    mis0 = mis_cnt;
    do_req(1, 1, 32'h203, 32'hAB, 0);
    wait_resp();
    chk("bst addr", hs_addr, 32'h200);
    chk("bst mask", hs_mask, 4'b1000);
    chk("bst wdata", hs_wdata, 32'hABAB_ABAB);
    chk("bst misalign", mis_cnt - mis0, 0);
    chk("bst owner", resp_owner, 1);

    // backpressure
    mem_stall = 5;
    mem_word = 32'h0000_55AA;
    memv_cnt = 0;
    do_req(0, 1, 32'h40, 32'hCAFE_F00D, 2);
    wait_resp();
    mem_stall = 0;
    chk("bp valid cycles", memv_cnt, 6);
    chk("bp mask", hs_mask, 4'hF);
    chk("bp wdata", hs_wdata, 32'hCAFE_F00D);
    chk("bp data", resp_dat, 32'h0000_55AA);
    chk("bp owner", resp_owner, 0);

    // misaligned half store
    mis0 = mis_cnt;
    do_req(0, 1, 32'h301, 32'h1234_CDEF, 1);
    wait_resp();
    chk("mh pulse", mis_cnt - mis0, 1);
    chk("mh mask", hs_mask, 4'b0011);
    chk("mh wdata", hs_wdata, 32'hCDEF_CDEF);
    chk("mh addr", hs_addr, 32'h300);

    // aligned upper half, misaligned word, byte load
    mis0 = mis_cnt;
    do_req(0, 1, 32'h302, 32'h0000_BEEF, 1);
    wait_resp();
    chk("hu mask", hs_mask, 4'b1100);
    chk("hu misalign", mis_cnt - mis0, 0);
    do_req(1, 1, 32'h402, 32'h0102_0304, 3);
    wait_resp();
    chk("mw mask", hs_mask, 4'hF);
    chk("mw addr", hs_addr, 32'h400);
    chk("mw misalign", mis_cnt - mis0, 1);
    do_req(1, 0, 32'h45, 32'hFFFF_FFFF, 0);
    wait_resp();
    chk("bl mask", hs_mask, 4'hF);
    chk("bl wdata", hs_wdata, 0);

    // timeout
    mem_mute = 1;
    do_req(1, 0, 32'h80, 0, 2);
    wait_resp();
    chk("to wait", resp_cyc - hs_cyc, TO + 2);
    chk("to data", resp_dat, ERR);
    chk("to owner", resp_owner, 1);
    chk("to flag", timeout_err, 1);
    mem_mute = 0;
    mem_word = 32'h0BAD_CAFE;
    do_req(0, 0, 32'h84, 0, 2);
    wait_resp();
    @(negedge clock);
    chk("to sticky", timeout_err, 1);

    // reset while in WAIT
    mem_mute = 1;
    do_req(0, 0, 32'h90, 0, 2);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
    rc0 = resp_cnt;
    @(negedge clock);
    chk("rw mem_req_valid", mem_req_valid, 0);
    chk("rw timeout_err", timeout_err, 0);
    repeat (15) @(negedge clock);
    chk("rw no resp", resp_cnt - rc0, 0);
    mem_mute = 0;

    // recovery after reset
    mem_word = 32'hA5A5_5A5A;
    do_req(1, 0, 32'h88, 0, 2);
    wait_resp();
    chk("rec data", resp_dat, 32'hA5A5_5A5A);
    chk("rec owner", resp_owner, 1);

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
